// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack imem port, one-entry output buffer to decode.
// Define IF_PERF_CNT_EN to add the fetch and flush performance counters.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_pc,
   output logic [31:0] o_out_instr,
   input  logic [1:0]  i_redir_sel,
   input  logic [31:0] i_branch_target,
   input  logic [31:0] i_jump_target,
   input  logic [31:0] i_jr_target
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_fetch_cnt,
   output logic [31:0] o_perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_FETCH   = 2'd1,
      S_BLOCKED = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_pc;
   logic        r_out_valid;
   logic [31:0] r_out_pc;
   logic [31:0] r_out_instr;

   logic        w_buf_free;
   logic        w_redir;
   logic        w_req;
   logic        w_capture;
   logic [31:0] w_target;

   assign w_buf_free = !r_out_valid || i_out_ready;
   assign w_redir    = (i_redir_sel != 2'b00);
   assign w_capture  = w_req && i_imem_ack;

   always_comb begin
      w_target = i_branch_target;
      unique case (i_redir_sel)
         2'b10:   w_target = i_jump_target;
         2'b11:   w_target = i_jr_target;
         default: w_target = i_branch_target;
      endcase
   end

   // Redirect overrides everything: request is withheld so a same-cycle ack is discarded.
   always_comb begin
      w_state_next = r_state;
      w_req        = 1'b0;
      unique case (r_state)
         S_IDLE: w_state_next = S_FETCH;
         S_FETCH: begin
            if (r_out_valid && !i_out_ready)
               w_state_next = S_BLOCKED;
            else
               w_req = 1'b1;
         end
         S_BLOCKED: begin
            if (i_out_ready)
               w_state_next = S_FETCH;
         end
         default: w_state_next = S_IDLE;
      endcase
      if (w_redir) begin
         w_req        = 1'b0;
         w_state_next = S_FETCH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_out_valid <= 1'b0;
         r_out_pc    <= 32'd0;
         r_out_instr <= 32'd0;
      end else if (w_redir) begin
         r_pc        <= w_target;
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_pc        <= r_pc + PC_STEP;
         r_out_valid <= 1'b1;
         r_out_pc    <= r_pc;
         r_out_instr <= i_imem_rdata;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_perf_fetch_cnt;
   logic [31:0] r_perf_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch_cnt <= 32'd0;
         r_perf_flush_cnt <= 32'd0;
      end else begin
         if (w_capture)
            r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
         if (w_redir)
            r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      end
   end

   assign o_perf_fetch_cnt = r_perf_fetch_cnt;
   assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_out_valid = r_out_valid;
   assign o_out_pc    = r_out_pc;
   assign o_out_instr = r_out_instr;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural fetch model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [1:0]  redir_sel;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_ack      (imem_ack),
      .i_imem_rdata    (imem_rdata),
      .o_out_valid     (out_valid),
      .i_out_ready     (out_ready),
      .o_out_pc        (out_pc),
      .o_out_instr     (out_instr),
      .i_redir_sel     (redir_sel),
      .i_branch_target (branch_target),
      .i_jump_target   (jump_target),
      .i_jr_target     (jr_target)
`ifdef IF_PERF_CNT_EN
      ,
      .o_perf_fetch_cnt(perf_fetch_cnt),
      .o_perf_flush_cnt(perf_flush_cnt)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: "first" marks the idle cycle after reset, "stalled" marks the
   // cycle after decode refused a full buffer (fetch stays quiet one more cycle).
   bit          m_first;
   bit          m_stalled;
   bit          m_valid;
   logic [31:0] m_pc;
   logic [31:0] m_opc;
   logic [31:0] m_oinstr;
   logic [31:0] m_fcnt;
   logic [31:0] m_rcnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_first   = 1'b1;
      m_stalled = 1'b0;
      m_valid   = 1'b0;
      m_pc      = 32'h0000_3000;
      m_opc     = 32'd0;
      m_oinstr  = 32'd0;
      m_fcnt    = 32'd0;
      m_rcnt    = 32'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle's inputs, compare DUT against the model, then advance the model.
   task automatic step(input logic [1:0] rs, input logic [31:0] tgt, input logic ack,
                       input logic [31:0] rd, input logic rdy);
      bit exp_req;
      bit cap;
      redir_sel     = rs;
      branch_target = $urandom;
      jump_target   = $urandom;
      jr_target     = $urandom;
      case (rs)
         2'b01:   branch_target = tgt;
         2'b10:   jump_target   = tgt;
         2'b11:   jr_target     = tgt;
         default: ;
      endcase
      imem_ack   = ack;
      imem_rdata = rd;
      out_ready  = rdy;
      #1;
      exp_req = !m_first && !m_stalled && (!m_valid || rdy) && (rs == 2'b00);
      cap     = exp_req && ack;
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
         chk("out_pc", out_pc, m_opc);
         chk("out_instr", out_instr, m_oinstr);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
      chk("perf_flush_cnt", perf_flush_cnt, m_rcnt);
`endif
      if (rs != 2'b00) begin
         $display("redirect sel=%0d to %h", rs, tgt);
         m_rcnt++;
         m_pc      = tgt;
         m_valid   = 1'b0;
         m_stalled = 1'b0;
      end else begin
         m_stalled = !m_first && m_valid && !rdy;
         if (cap) begin
            $display("capture pc=%h instr=%h", m_pc, rd);
            m_fcnt++;
            m_opc    = m_pc;
            m_oinstr = rd;
            m_pc     = m_pc + 32'd4;
            m_valid  = 1'b1;
         end else if (rdy) begin
            m_valid = 1'b0;
         end
      end
      m_first = 1'b0;
   endtask

   task automatic chk_reset_values();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_addr", imem_addr, 32'h0000_3000);
`ifdef IF_PERF_CNT_EN
      chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      chk("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      redir_sel = 2'b00; branch_target = 0; jump_target = 0; jr_target = 0;
      imem_ack = 1'b0; imem_rdata = 0; out_ready = 1'b0;
      model_reset();
      repeat (3) tick();
      chk_reset_values();
      rst_n = 1'b1;

      // Straight-line fetch with immediate ack and ready decode
      step(2'b00, 0, 1'b1, 32'hA000_0000, 1'b1);
      chk("idle_no_req", {31'd0, imem_req}, 32'd0);
      tick();
      step(2'b00, 0, 1'b1, 32'hA000_0001, 1'b1);
      chk("first_addr", imem_addr, 32'h0000_3000);
      tick();
      step(2'b00, 0, 1'b1, 32'hA000_0002, 1'b1);
      chk("second_addr", imem_addr, 32'h0000_3004);
      chk("trail_pc", out_pc, 32'h0000_3000);
      chk("trail_instr", out_instr, 32'hA000_0001);
      tick();
      step(2'b00, 0, 1'b1, 32'hA000_0003, 1'b1);
      chk("third_addr", imem_addr, 32'h0000_3008);
      tick();

      // Decode back-pressure
      step(2'b00, 0, 1'b1, 32'hBAD0_0000, 1'b0);
      chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", out_pc, 32'h0000_3008);
      tick();
      step(2'b00, 0, 1'b1, 32'hBAD0_0001, 1'b0);
      chk("blocked_pc", out_pc, 32'h0000_3008);
      tick();
      step(2'b00, 0, 1'b1, 32'hBAD0_0002, 1'b1);
      chk("blocked_consume_no_req", {31'd0, imem_req}, 32'd0);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("after_block_valid", {31'd0, out_valid}, 32'd0);
      chk("after_block_addr", imem_addr, 32'h0000_300C);
      tick();

      // Delayed ack: address and request held, single capture
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h0000_300C);
      tick();
      step(2'b00, 0, 1'b1, 32'hC0DE_0001, 1'b1);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("late_cap_pc", out_pc, 32'h0000_300C);
      chk("late_cap_instr", out_instr, 32'hC0DE_0001);
      chk("late_next_addr", imem_addr, 32'h0000_3010);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("no_duplicate", {31'd0, out_valid}, 32'd0);
      tick();

      // Jump redirect coincident with an ack: data dropped
      step(2'b10, 32'h0040_0010, 1'b1, 32'hDEAD_0000, 1'b1);
      chk("redir_no_req", {31'd0, imem_req}, 32'd0);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("redir_flush", {31'd0, out_valid}, 32'd0);
      chk("redir_addr", imem_addr, 32'h0040_0010);
      tick();

      // PC wrap
      step(2'b11, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
      tick();
      step(2'b00, 0, 1'b1, 32'h1234_5678, 1'b1);
      chk("wrap_from", imem_addr, 32'hFFFF_FFFC);
      tick();
      step(2'b00, 0, 1'b0, 32'h0, 1'b1);
      chk("wrap_to", imem_addr, 32'h0000_0000);
      chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
      tick();

      // Randomized traffic, with one reset pulse in the middle
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            imem_ack = 1'b1;
            rst_n    = 1'b0;
            #1;
            chk_reset_values();
            model_reset();
            tick();
            rst_n = 1'b1;
         end else begin
            logic [1:0]  rs;
            rs = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(rs, $urandom, ($urandom_range(0, 9) < 6), $urandom,
                 ($urandom_range(0, 9) < 7));
            tick();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
